// File: rtl/stream_decryptor.sv
// Byte-serial Vigenere decryptor over 'A'..'Z' with a loadable key RAM,
// a one-entry output register and MSG_LEN message framing.
module stream_decryptor #(
  parameter int MSG_LEN = 6,
  parameter int SEC_LEN = 7,
  localparam int KW = (SEC_LEN > 1) ? $clog2(SEC_LEN) : 1,
  localparam int CW = (MSG_LEN > 1) ? $clog2(MSG_LEN) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          key_wr,
  input  logic [KW-1:0] key_idx,
  input  logic [7:0]    key_data,
  output logic          key_err,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [7:0]    in_data,
  input  logic          in_last,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [7:0]    out_data,
  output logic          out_last,
  output logic          out_err,
  output logic          len_err,
  output logic          busy
);

  // Handshake: a byte moves on in_* when in_valid && in_ready at the rising
  // edge, and leaves on out_* when out_valid && out_ready at the rising edge.

  typedef enum logic { IDLE = 1'b0, RUN = 1'b1 } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [KW-1:0] kidx_q, kidx_d;
  logic          ov_q, ov_d;
  logic [7:0]    od_q, od_d;
  logic          ol_q, ol_d;
  logic          oe_q, oe_d;
  logic          len_err_q, len_err_d;
  logic          key_err_q, key_err_d;
  logic [4:0]    key_q [SEC_LEN];

  logic          key_we;
  logic          key_ok;
  logic [4:0]    key_pos;
  logic          in_ok;
  logic [4:0]    in_pos;
  logic [4:0]    key_k;
  logic [5:0]    diff;
  logic [7:0]    dec;
  logic          accept;
  logic          cnt_max;
  logic          final_byte;

  assign key_ok  = (key_data >= 8'h41) && (key_data <= 8'h5A);
  assign key_pos = key_ok ? 5'(key_data - 8'h41) : 5'd0;
  assign key_we  = (state_q == IDLE) && key_wr && (int'(key_idx) < SEC_LEN);

  assign in_ok   = (in_data >= 8'h41) && (in_data <= 8'h5A);
  assign in_pos  = 5'(in_data - 8'h41);
  assign key_k   = key_q[kidx_q];

  // Adding 26 before subtracting keeps the difference non-negative in 6 bits.
  always_comb begin
    diff = 6'(in_pos) + 6'd26 - 6'(key_k);
    if (diff >= 6'd26) diff = diff - 6'd26;
    dec = 8'h41 + 8'(diff);
  end

  assign in_ready   = (state_q == RUN) && (!ov_q || out_ready);
  assign accept     = in_valid && in_ready;
  assign cnt_max    = (cnt_q == CW'(MSG_LEN - 1));
  assign final_byte = in_last || cnt_max;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    kidx_d    = kidx_q;
    ov_d      = ov_q;
    od_d      = od_q;
    ol_d      = ol_q;
    oe_d      = oe_q;
    len_err_d = len_err_q;
    key_err_d = key_err_q;

    if (key_we && !key_ok) key_err_d = 1'b1;

    if (ov_q && out_ready) ov_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (!key_wr && in_valid) state_d = RUN;
      end
      RUN: begin
        if (accept) begin
          ov_d = 1'b1;
          od_d = in_ok ? dec : in_data;
          oe_d = !in_ok;
          ol_d = final_byte;
          if ((in_last && !cnt_max) || (!in_last && cnt_max)) len_err_d = 1'b1;
          if (final_byte) begin
            cnt_d   = '0;
            kidx_d  = '0;
            state_d = IDLE;
          end else begin
            cnt_d = cnt_q + 1'b1;
            // Pass-through bytes do not consume a key position.
            if (in_ok) kidx_d = (kidx_q == KW'(SEC_LEN - 1)) ? '0 : kidx_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      kidx_q    <= '0;
      ov_q      <= 1'b0;
      od_q      <= 8'h00;
      ol_q      <= 1'b0;
      oe_q      <= 1'b0;
      len_err_q <= 1'b0;
      key_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      kidx_q    <= kidx_d;
      ov_q      <= ov_d;
      od_q      <= od_d;
      ol_q      <= ol_d;
      oe_q      <= oe_d;
      len_err_q <= len_err_d;
      key_err_q <= key_err_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < SEC_LEN; i++) key_q[i] <= 5'd0;
    end else if (key_we) begin
      key_q[key_idx] <= key_pos;
    end
  end

  assign out_valid = ov_q;
  assign out_data  = od_q;
  assign out_last  = ol_q;
  assign out_err   = oe_q;
  assign len_err   = len_err_q;
  assign key_err   = key_err_q;
  assign busy      = (state_q == RUN);

endmodule

// File: tb/tb_stream_decryptor.sv
// Directed bench for stream_decryptor: hand-computed plaintext per frame,
// back-pressure, framing errors and asynchronous reset.
module tb_stream_decryptor;

  logic       clk = 1'b0;
  logic       rst;
  logic       key_wr;
  logic [2:0] key_idx;
  logic [7:0] key_data;
  logic       key_err;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       in_last;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic       out_last;
  logic       out_err;
  logic       len_err;
  logic       busy;

  int checks = 0;
  int errors = 0;

  stream_decryptor #(.MSG_LEN(6), .SEC_LEN(7)) dut (
    .clk(clk), .rst(rst),
    .key_wr(key_wr), .key_idx(key_idx), .key_data(key_data), .key_err(key_err),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last), .out_err(out_err), .len_err(len_err), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic write_key(input int idx, input logic [7:0] ch);
    key_wr = 1'b1; key_idx = 3'(idx); key_data = ch;
    @(posedge clk); #1;
    key_wr = 1'b0;
  endtask

  task automatic load_key(input string k);
    for (int i = 0; i < 7; i++) write_key(i, k[i]);
  endtask

  // Offers one byte, waits for acceptance, then checks the output register.
  task automatic send(input string tag, input logic [7:0] d, input logic last,
                      input logic [7:0] exp_d, input logic exp_err,
                      input logic exp_last, output int waits);
    #1;
    in_valid = 1'b1; in_data = d; in_last = last;
    waits = 0;
    while (!in_ready && waits < 50) begin
      @(posedge clk); #1;
      waits++;
    end
    if (waits >= 50) chk({tag, "_timeout"}, 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0; in_last = 1'b0;
    chk({tag, "_valid"}, 32'(out_valid), 32'd1);
    chk({tag, "_data"},  32'(out_data),  32'(exp_d));
    chk({tag, "_err"},   32'(out_err),   32'(exp_err));
    chk({tag, "_last"},  32'(out_last),  32'(exp_last));
  endtask

  task automatic frame(input string tag, input string ct, input string pt,
                       input logic [5:0] errs, input int last_pos);
    int w;
    for (int i = 0; i < ct.len(); i++)
      send($sformatf("%s_b%0d", tag, i), ct[i], (i == last_pos), pt[i], errs[i],
           (i == ct.len() - 1), w);
  endtask

  task automatic do_reset;
    rst = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    int w;
    rst = 1'b1; key_wr = 1'b0; key_idx = '0; key_data = '0;
    in_valid = 1'b0; in_data = '0; in_last = 1'b0; out_ready = 1'b1;
    #2;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready",  32'(in_ready),  32'd0);
    chk("rst_busy",      32'(busy),      32'd0);
    chk("rst_key_err",   32'(key_err),   32'd0);
    chk("rst_len_err",   32'(len_err),   32'd0);
    chk("rst_out_data",  32'(out_data),  32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // K=10 E=4 Y=24: R-K=H, I-E=E, J-Y=L, V-K=L, S-E=O, X-Y=Z
    load_key("KEYKEYK");
    frame("hello", "RIJVSX", "HELLOZ", 6'b000000, 5);
    chk("hello_len_err", 32'(len_err), 32'd0);
    chk("hello_key_err", 32'(key_err), 32'd0);

    load_key("AAAAAAA");
    frame("inval", "@#$%^&", "@#$%^&", 6'b111111, 5);
    chk("inval_len_err", 32'(len_err), 32'd0);

    // A-B=Z, '1' passes through without consuming 'C', B-C=Z, then key A.
    write_key(0, "B");
    write_key(1, "C");
    frame("mixed", "A1BAAA", "Z1ZAAA", 6'b000010, 5);

    // key0=Z: A-Z=B; key1=C: A-C=Y.
    write_key(0, "Z");
    frame("wrap", "AAAAAA", "BYAAAA", 6'b000000, 5);
    chk("wrap_len_err", 32'(len_err), 32'd0);

    load_key("KEYKEYK");
    send("bp_b0", "R", 1'b0, "H", 1'b0, 1'b0, w);
    send("bp_b1", "I", 1'b0, "E", 1'b0, 1'b0, w);
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = "J"; in_last = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk($sformatf("bp_hold%0d_data", i),  32'(out_data),  32'("E"));
      chk($sformatf("bp_hold%0d_valid", i), 32'(out_valid), 32'd1);
      chk($sformatf("bp_hold%0d_ready", i), 32'(in_ready),  32'd0);
    end
    out_ready = 1'b1;
    send("bp_b2", "J", 1'b0, "L", 1'b0, 1'b0, w);
    send("bp_b3", "V", 1'b0, "L", 1'b0, 1'b0, w);
    chk("bp_b3_nostall", 32'(w), 32'd0);
    send("bp_b4", "S", 1'b0, "O", 1'b0, 1'b0, w);
    chk("bp_b4_nostall", 32'(w), 32'd0);
    send("bp_b5", "X", 1'b1, "Z", 1'b0, 1'b1, w);
    chk("bp_b5_nostall", 32'(w), 32'd0);
    chk("bp_len_err", 32'(len_err), 32'd0);

    // Cleared key RAM means identity shift.
    do_reset();
    chk("short_pre_len_err", 32'(len_err), 32'd0);
    write_key(7, "?");
    chk("idx_oob_key_err", 32'(key_err), 32'd0);
    send("short_b0", "A", 1'b0, "A", 1'b0, 1'b0, w);
    send("short_b1", "B", 1'b0, "B", 1'b0, 1'b0, w);
    send("short_b2", "C", 1'b1, "C", 1'b0, 1'b1, w);
    chk("short_len_err", 32'(len_err), 32'd1);

    do_reset();
    chk("long_pre_len_err", 32'(len_err), 32'd0);
    frame("nolast", "ABCDEF", "ABCDEF", 6'b000000, 99);
    chk("nolast_len_err", 32'(len_err), 32'd1);

    do_reset();
    load_key("KEYKEYK");
    write_key(6, "1");
    chk("badkey_key_err", 32'(key_err), 32'd1);
    send("ar_b0", "R", 1'b0, "H", 1'b0, 1'b0, w);
    send("ar_b1", "I", 1'b0, "E", 1'b0, 1'b0, w);
    out_ready = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("ar_out_valid", 32'(out_valid), 32'd0);
    chk("ar_busy",      32'(busy),      32'd0);
    chk("ar_key_err",   32'(key_err),   32'd0);
    out_ready = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    load_key("KEYKEYK");
    frame("ar_again", "RIJVSX", "HELLOZ", 6'b000000, 5);
    chk("ar_again_len_err", 32'(len_err), 32'd0);

    @(posedge clk); #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: observed running expected finished");
    $fatal(1, "timeout");
  end

endmodule
